fix_serializer: RTL and testbench

- FIX message transmitter: the outbound counterpart of the FIX parser.
- Accepts a byte stream of tag and value segments.
- Inserts '=' after each tag and SOH after each value.
- Computes the FIX checksum and appends the trailer "10=NNN<SOH>".
- Packs bytes into 32-bit words with a byte-valid mask, the same word/mask format the parser consumes, for loopback and egress.

---
 rtl/fix_serializer_pkg.sv | 46 ++++
 rtl/fix_serializer_if.sv | 25 ++
 rtl/fix_serializer_packer.sv | 81 ++++++++
 rtl/fix_serializer.sv | 149 ++++++++++++++
 tb/tb_fix_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fix_serializer_pkg.sv
// Shared FIX definitions for the serializer and parser paths:
// delimiter constants, serializer FSM states and the byte-mask type.
package fix_pkg;

    localparam logic [7:0]  FIX_SOH    = 8'h01;
    localparam logic [7:0]  FIX_EQ     = 8'h3D;
    localparam logic [15:0] FIX_CK_TAG = 16'h3130;

    typedef logic [3:0] fix_mask_t;

    typedef enum logic [3:0] {
        S_TAG,
        S_INS_EQ,
        S_VALUE,
        S_INS_SOH,
        S_CK_1,
        S_CK_0,
        S_CK_EQ,
        S_CK_D2,
        S_CK_D1,
        S_CK_D0,
        S_CK_SOH,
        S_FLUSH
    } fix_ser_state_t;

    function automatic fix_mask_t fix_partial_mask(input logic [1:0] n);
        case (n)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Zero-padded three-digit ASCII rendering of the checksum, hundreds in [23:16].
    function automatic logic [23:0] fix_ck_digits(input logic [7:0] cs);
        logic [7:0] h;
        logic [7:0] t;
        logic [7:0] u;
        h = 8'h30 + cs / 8'd100;
        t = 8'h30 + (cs / 8'd10) % 8'd10;
        u = 8'h30 + cs % 8'd10;
        return {h, t, u};
    endfunction

endpackage

// File: rtl/fix_serializer_if.sv
// Byte-segment input stream and packed word output stream of the FIX serializer.
interface fix_serializer_if;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [7:0]        in_data_i;
    logic              in_eof_i;
    logic              in_eom_i;
    logic [31:0]       out_o;
    fix_pkg::fix_mask_t out_valid_o;
    logic              out_last_o;
    logic              out_ready_i;
    logic              err_o;

    modport master (
        output in_valid_i, in_data_i, in_eof_i, in_eom_i, out_ready_i,
        input  in_ready_o, out_o, out_valid_o, out_last_o, err_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_eof_i, in_eom_i, out_ready_i,
        output in_ready_o, out_o, out_valid_o, out_last_o, err_o
    );

endinterface

// File: rtl/fix_serializer_packer.sv
// Byte-to-word accumulator with a single output register; a completed word or a
// flushed partial moves to the output register one cycle after its last byte.
module fix_word_packer
    import fix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_last_i,
    input  logic        flush_i,
    output logic        can_accept_o,
    output logic [31:0] out_o,
    output fix_mask_t   out_valid_o,
    output logic        out_last_o,
    input  logic        out_ready_i
);

    logic [31:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    fix_mask_t   mask_q, mask_d;
    logic        last_q, last_d;
    logic        slotFree;

    // Only a word-completing byte or a non-empty flush needs the output slot.
    assign slotFree     = (mask_q == 4'b0000) || out_ready_i;
    assign can_accept_o = slotFree || (flush_i ? (cnt_q == 2'd0) : (cnt_q != 2'd3));

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        mask_d = mask_q;
        last_d = last_q;
        if ((mask_q != 4'b0000) && out_ready_i) begin
            word_d = '0;
            mask_d = '0;
            last_d = 1'b0;
        end
        if (byte_valid_i && can_accept_o) begin
            if (cnt_q == 2'd3) begin
                word_d = {byte_data_i, acc_q[23:0]};
                mask_d = 4'b1111;
                last_d = byte_last_i;
                acc_d  = '0;
                cnt_d  = 2'd0;
            end else begin
                acc_d[{cnt_q, 3'b000} +: 8] = byte_data_i;
                cnt_d = cnt_q + 2'd1;
            end
        end else if (flush_i && can_accept_o && (cnt_q != 2'd0)) begin
            word_d = acc_q;
            mask_d = fix_partial_mask(cnt_q);
            last_d = 1'b1;
            acc_d  = '0;
            cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            mask_q <= '0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            mask_q <= mask_d;
            last_q <= last_d;
        end
    end

    assign out_o       = word_q;
    assign out_valid_o = mask_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/fix_serializer.sv
// FIX message transmitter: inserts '=' and SOH around tag/value segments, optionally
// appends the "10=NNN" checksum trailer, and packs the byte stream into 32-bit words.
module fix_serializer
    import fix_pkg::*;
#(
    parameter bit         CK_EN    = 1'b1,
    parameter logic [7:0] SOH_CHAR = FIX_SOH
) (
    input  logic             clk,
    input  logic             rst,
    fix_serializer_if.slave  bus
);

    fix_ser_state_t state_q, state_d, ckNext;
    logic [7:0]     cksum_q, cksum_d;
    logic [23:0]    digits_q, digits_d;
    logic           eom_q, eom_d;
    logic           err_q, err_d;
    logic           byteValid, byteLast, flush, canAccept, inReady, sumByte, trailer;
    logic [7:0]     byteData;

    always_comb begin
        state_d   = state_q;
        cksum_d   = cksum_q;
        digits_d  = digits_q;
        eom_d     = eom_q;
        err_d     = err_q;
        byteValid = 1'b0;
        byteData  = 8'h00;
        byteLast  = 1'b0;
        flush     = 1'b0;
        inReady   = 1'b0;
        sumByte   = 1'b0;
        trailer   = 1'b0;
        ckNext    = state_q;
        case (state_q)
            S_TAG: begin
                inReady  = canAccept;
                byteData = bus.in_data_i;
                if (bus.in_valid_i && canAccept) begin
                    byteValid = 1'b1;
                    sumByte   = 1'b1;
                    if ((bus.in_data_i < 8'h30) || (bus.in_data_i > 8'h39)) err_d = 1'b1;
                    if (bus.in_eof_i) begin
                        state_d = S_INS_EQ;
                        if (bus.in_eom_i) err_d = 1'b1;
                    end
                end
            end
            S_INS_EQ: begin
                byteData = FIX_EQ;
                if (canAccept) begin
                    byteValid = 1'b1;
                    sumByte   = 1'b1;
                    state_d   = S_VALUE;
                end
            end
            S_VALUE: begin
                inReady  = canAccept;
                byteData = bus.in_data_i;
                if (bus.in_valid_i && canAccept) begin
                    byteValid = 1'b1;
                    sumByte   = 1'b1;
                    if (bus.in_eof_i) begin
                        eom_d   = bus.in_eom_i;
                        state_d = S_INS_SOH;
                    end
                end
            end
            S_INS_SOH: begin
                byteData = SOH_CHAR;
                byteLast = eom_q && !CK_EN;
                if (canAccept) begin
                    byteValid = 1'b1;
                    sumByte   = 1'b1;
                    eom_d     = 1'b0;
                    if (!eom_q) begin
                        state_d = S_TAG;
                    end else if (CK_EN) begin
                        state_d  = S_CK_1;
                        digits_d = fix_ck_digits(cksum_q + SOH_CHAR);
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_CK_1:   begin byteData = FIX_CK_TAG[15:8]; trailer = 1'b1; ckNext = S_CK_0;   end
            S_CK_0:   begin byteData = FIX_CK_TAG[7:0];  trailer = 1'b1; ckNext = S_CK_EQ;  end
            S_CK_EQ:  begin byteData = FIX_EQ;           trailer = 1'b1; ckNext = S_CK_D2;  end
            S_CK_D2:  begin byteData = digits_q[23:16];  trailer = 1'b1; ckNext = S_CK_D1;  end
            S_CK_D1:  begin byteData = digits_q[15:8];   trailer = 1'b1; ckNext = S_CK_D0;  end
            S_CK_D0:  begin byteData = digits_q[7:0];    trailer = 1'b1; ckNext = S_CK_SOH; end
            S_CK_SOH: begin
                byteData = SOH_CHAR;
                byteLast = 1'b1;
                trailer  = 1'b1;
                ckNext   = S_FLUSH;
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (canAccept) begin
                    state_d = S_TAG;
                    cksum_d = '0;
                end
            end
            default: state_d = S_TAG;
        endcase
        if (trailer && canAccept) begin
            byteValid = 1'b1;
            state_d   = ckNext;
        end
        // Trailer bytes are excluded from the running sum.
        if (sumByte) cksum_d = cksum_q + byteData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_TAG;
            cksum_q  <= '0;
            digits_q <= '0;
            eom_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cksum_q  <= cksum_d;
            digits_q <= digits_d;
            eom_q    <= eom_d;
            err_q    <= err_d;
        end
    end

    fix_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (byteValid),
        .byte_data_i  (byteData),
        .byte_last_i  (byteLast),
        .flush_i      (flush),
        .can_accept_o (canAccept),
        .out_o        (bus.out_o),
        .out_valid_o  (bus.out_valid_o),
        .out_last_o   (bus.out_last_o),
        .out_ready_i  (bus.out_ready_i)
    );

    assign bus.in_ready_o = inReady && !rst;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer: one instance with the checksum trailer and SOH=0x01,
// one without the trailer and SOH='|'; words are collected as {last, mask, data}.
module tb_fix_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  inData = 8'h00;
    logic        inEof = 1'b0;
    logic        inEom = 1'b0;
    logic        outReady = 1'b1;
    int          errors = 0;
    int          checks = 0;
    logic [36:0] words[$];

    logic        inReadyM;
    logic [31:0] outM;
    logic [3:0]  outValidM;
    logic        outLastM;
    logic        errM;

    always #5 clk = ~clk;

    fix_serializer_if ifa();
    fix_serializer_if ifb();

    assign ifa.in_valid_i  = inValid && !sel;
    assign ifa.in_data_i   = inData;
    assign ifa.in_eof_i    = inEof;
    assign ifa.in_eom_i    = inEom;
    assign ifa.out_ready_i = sel ? 1'b1 : outReady;
    assign ifb.in_valid_i  = inValid && sel;
    assign ifb.in_data_i   = inData;
    assign ifb.in_eof_i    = inEof;
    assign ifb.in_eom_i    = inEom;
    assign ifb.out_ready_i = sel ? outReady : 1'b1;

    assign inReadyM  = sel ? ifb.in_ready_o  : ifa.in_ready_o;
    assign outM      = sel ? ifb.out_o       : ifa.out_o;
    assign outValidM = sel ? ifb.out_valid_o : ifa.out_valid_o;
    assign outLastM  = sel ? ifb.out_last_o  : ifa.out_last_o;
    assign errM      = sel ? ifb.err_o       : ifa.err_o;

    fix_serializer #(.CK_EN(1'b1), .SOH_CHAR(8'h01)) dut_ck (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    fix_serializer #(.CK_EN(1'b0), .SOH_CHAR(8'h7C)) dut_nock (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // A word is taken at the posedge following a negedge where valid and ready are both high.
    always begin
        @(negedge clk);
        #1;
        if ((outValidM != 4'h0) && outReady) words.push_back({outLastM, outValidM, outM});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic eof, input logic eom);
        int n = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = d;
        inEof   = eof;
        inEom   = eom;
        #1;
        while ((inReadyM !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout byte=%h in_ready=%b expected 1", d, inReadyM);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        inValid = 1'b0;
        inEof   = 1'b0;
        inEom   = 1'b0;
    endtask

    task automatic send_seg(input string s, input logic eom);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], (i == s.len() - 1), eom && (i == s.len() - 1));
    endtask

    task automatic send_msg(input string tag, input string val);
        send_seg(tag, 1'b0);
        send_seg(val, 1'b1);
        idle();
    endtask

    task automatic wait_words(input int n, output bit ok);
        int c = 0;
        while ((words.size() < n) && (c < 300)) begin
            @(negedge clk);
            #2;
            c++;
        end
        ok = (words.size() >= n);
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (inReadyM !== 1'b0)  begin errors++; $display("[TB] FAIL rst_in_ready got=%b expected=0", inReadyM); end
        checks++; if (outM !== 32'h0)     begin errors++; $display("[TB] FAIL rst_out got=%h expected=0", outM); end
        checks++; if (outValidM !== 4'h0) begin errors++; $display("[TB] FAIL rst_mask got=%h expected=0", outValidM); end
        checks++; if (outLastM !== 1'b0)  begin errors++; $display("[TB] FAIL rst_last got=%b expected=0", outLastM); end
        checks++; if (errM !== 1'b0)      begin errors++; $display("[TB] FAIL rst_err got=%b expected=0", errM); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (inReadyM !== 1'b1)  begin errors++; $display("[TB] FAIL post_rst_in_ready got=%b expected=1", inReadyM); end
    endtask

    task automatic test_checksum_msg();
        logic [36:0] want[3] = '{{1'b0, 4'hF, 32'h303D3533}, {1'b0, 4'hF, 32'h3D303101}, {1'b1, 4'hF, 32'h01343132}};
        logic [36:0] got;
        bit ok;
        words.delete();
        sel = 1'b0;
        outReady = 1'b1;
        send_msg("35", "0");
        wait_words(3, ok);
        checks++; if (words.size() != 3) begin errors++; $display("[TB] FAIL ck_count got=%0d expected=3", words.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL ck_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
        checks++; if (errM !== 1'b0) begin errors++; $display("[TB] FAIL ck_err got=%b expected=0", errM); end
    endtask

    task automatic test_short_value();
        logic [36:0] want[2] = '{{1'b0, 4'hF, 32'h313D3031}, {1'b1, 4'h7, 32'h00013637}};
        logic [36:0] got;
        bit ok;
        words.delete();
        send_msg("1", "A");
        wait_words(3, ok);
        checks++; if (words.size() != 3) begin errors++; $display("[TB] FAIL short_count got=%0d expected=3", words.size()); end
        got = (words.size() > 0) ? words[0] : 37'h0;
        checks++; if (got !== {1'b0, 4'hF, 32'h01413D31}) begin errors++; $display("[TB] FAIL short_word0 got=%h expected=%h", got, {1'b0, 4'hF, 32'h01413D31}); end
        for (int i = 0; i < 2; i++) begin
            got = (i + 1 < words.size()) ? words[i + 1] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL short_word%0d got=%h expected=%h (last,mask,data)", i + 1, got, want[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [36:0] want[3] = '{{1'b0, 4'hF, 32'h303D3533}, {1'b0, 4'hF, 32'h3D303101}, {1'b1, 4'hF, 32'h01343132}};
        logic [36:0] got;
        bit ok;
        words.delete();
        @(negedge clk);
        outReady = 1'b0;
        send_msg("35", "0");
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ((outM !== 32'h303D3533) || (outValidM !== 4'hF)) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got data=%h mask=%h expected data=303d3533 mask=f", c, outM, outValidM);
            end
            @(negedge clk);
        end
        outReady = 1'b1;
        wait_words(3, ok);
        checks++; if (words.size() != 3) begin errors++; $display("[TB] FAIL stall_count got=%0d expected=3", words.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL stall_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
    endtask

    task automatic test_input_stall();
        logic [36:0] want[5] = '{{1'b0, 4'hF, 32'h34333231}, {1'b0, 4'hF, 32'h38373635},
                                 {1'b0, 4'hF, 32'h3101303D}, {1'b0, 4'hF, 32'h31303D30},
                                 {1'b1, 4'h3, 32'h00000138}};
        logic [36:0] got;
        bit ok;
        words.delete();
        @(negedge clk);
        outReady = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h31 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b1;
        inData  = 8'h38;
        inEof   = 1'b1;
        inEom   = 1'b0;
        #1;
        checks++; if (inReadyM !== 1'b0) begin errors++; $display("[TB] FAIL in_stall_ready got=%b expected=0", inReadyM); end
        checks++; if (outM !== 32'h34333231) begin errors++; $display("[TB] FAIL in_stall_hold got=%h expected=34333231", outM); end
        @(negedge clk);
        outReady = 1'b1;
        #1;
        checks++; if (inReadyM !== 1'b1) begin errors++; $display("[TB] FAIL in_stall_release got=%b expected=1", inReadyM); end
        @(posedge clk);
        send_seg("0", 1'b1);
        idle();
        wait_words(5, ok);
        checks++; if (words.size() != 5) begin errors++; $display("[TB] FAIL in_stall_count got=%0d expected=5", words.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL in_stall_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
    endtask

    task automatic test_tag_error();
        logic [36:0] want[3] = '{{1'b0, 4'hF, 32'h01313D41}, {1'b0, 4'hF, 32'h313D3031}, {1'b1, 4'h7, 32'h00013637}};
        logic [36:0] got;
        bit ok;
        words.delete();
        #1;
        checks++; if (errM !== 1'b0) begin errors++; $display("[TB] FAIL tag_err_before got=%b expected=0", errM); end
        send_byte(8'h41, 1'b1, 1'b0);
        idle();
        #1;
        checks++; if (errM !== 1'b1) begin errors++; $display("[TB] FAIL tag_err_set got=%b expected=1", errM); end
        send_seg("1", 1'b1);
        idle();
        wait_words(3, ok);
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL tag_err_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
        checks++; if (errM !== 1'b1) begin errors++; $display("[TB] FAIL tag_err_sticky got=%b expected=1", errM); end
    endtask

    task automatic test_mid_reset();
        logic [36:0] want[2] = '{{1'b0, 4'hF, 32'h01413D31}, {1'b0, 4'hF, 32'h313D3031}};
        logic [36:0] got;
        bit ok;
        words.delete();
        @(negedge clk);
        outReady = 1'b0;
        send_seg("1", 1'b0);
        send_byte(8'h41, 1'b0, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (outValidM !== 4'h0) begin errors++; $display("[TB] FAIL mid_rst_mask got=%h expected=0", outValidM); end
        checks++; if (outM !== 32'h0)     begin errors++; $display("[TB] FAIL mid_rst_out got=%h expected=0", outM); end
        checks++; if (outLastM !== 1'b0)  begin errors++; $display("[TB] FAIL mid_rst_last got=%b expected=0", outLastM); end
        checks++; if (errM !== 1'b0)      begin errors++; $display("[TB] FAIL mid_rst_err got=%b expected=0", errM); end
        checks++; if (inReadyM !== 1'b0)  begin errors++; $display("[TB] FAIL mid_rst_in_ready got=%b expected=0", inReadyM); end
        rst = 1'b0;
        outReady = 1'b1;
        send_msg("1", "A");
        wait_words(3, ok);
        checks++; if (words.size() != 3) begin errors++; $display("[TB] FAIL mid_rst_count got=%0d expected=3", words.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL mid_rst_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
        got = (words.size() > 2) ? words[2] : 37'h0;
        checks++; if (got !== {1'b1, 4'h7, 32'h00013637}) begin errors++; $display("[TB] FAIL mid_rst_word2 got=%h expected=%h", got, {1'b1, 4'h7, 32'h00013637}); end
    endtask

    task automatic test_no_checksum();
        logic [36:0] want[4] = '{{1'b0, 4'hF, 32'h49463D38}, {1'b1, 4'h3, 32'h00007C58},
                                 {1'b0, 4'hF, 32'h49463D38}, {1'b1, 4'h1, 32'h0000007C}};
        logic [36:0] got;
        bit ok;
        words.delete();
        @(negedge clk);
        sel = 1'b1;
        outReady = 1'b1;
        send_msg("8", "FIX");
        send_msg("8", "FI");
        wait_words(4, ok);
        checks++; if (words.size() != 4) begin errors++; $display("[TB] FAIL nock_count got=%0d expected=4", words.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < words.size()) ? words[i] : 37'h0;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("[TB] FAIL nock_word%0d got=%h expected=%h (last,mask,data)", i, got, want[i]);
            end
        end
        checks++; if (errM !== 1'b0) begin errors++; $display("[TB] FAIL nock_err got=%b expected=0", errM); end
    endtask

    initial begin
        test_reset();
        test_checksum_msg();
        test_short_value();
        test_stall();
        test_input_stall();
        test_tag_error();
        test_mid_reset();
        test_no_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
